// File: rtl/com_pkg.sv
// Shared definitions for the Com-side memory loader and its helpers.
package com_pkg;

   localparam int          BYTE_W        = 8;
   localparam int          TIMEOUT_DEF   = 50000;
   localparam logic [15:0] BASE_ADDR_DEF = 16'h0000;

   // Loader sequencing: count bytes, then high/low data bytes, then a write.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CNT_HI = 3'd1,
      ST_CNT_LO = 3'd2,
      ST_DAT_HI = 3'd3,
      ST_DAT_LO = 3'd4,
      ST_WRITE  = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   // States in which the loader owns the memory port (com_en high).
   function automatic logic owns_port(input state_t st);
      logic r;
      case (st)
         ST_CNT_HI, ST_CNT_LO, ST_DAT_HI, ST_DAT_LO, ST_WRITE: r = 1'b1;
         default:                                             r = 1'b0;
      endcase
      return r;
   endfunction

   // States that are waiting on the receiver and so run the inter-byte timer.
   function automatic logic waits_rx(input state_t st);
      logic r;
      case (st)
         ST_CNT_HI, ST_CNT_LO, ST_DAT_HI, ST_DAT_LO: r = 1'b1;
         default:                                   r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/com_timeout_ctr.sv
// Loadable down-counter with an expiry flag. A load wins over counting;
// the count stops at zero and expired stays high until the next load.
module com_timeout_ctr #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt_r;

   // Reload on request, otherwise count down while enabled and not at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (load) begin
         cnt_r <= load_val;
      end else if (en && (cnt_r != '0)) begin
         cnt_r <= cnt_r - W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expired = (cnt_r == '0);

endmodule

// File: rtl/com_loader.sv
// Com-side producer for the memory-select port: assembles bytes from the
// UART receiver into 16-bit words and issues one-cycle memory writes.
// Frame: count_hi, count_lo, then count words, each high byte first.
module com_loader
   import com_pkg::*;
#(
   parameter int                ADDR_W    = 16,
   parameter int                DATA_W    = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_ADDR_DEF),
   parameter int                TIMEOUT   = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              com_en,
   output logic              write_from_com,
   output logic [ADDR_W-1:0] add_from_com,
   output logic [DATA_W-1:0] dat_from_com,
   output logic              busy,
   output logic              done,
   output logic              error
);

   // Timer is loaded with TIMEOUT-1 and expires when it reaches zero, which
   // is the same moment an up-counter cleared to zero would reach TIMEOUT-1.
   localparam int              TO_W     = $clog2(TIMEOUT) + 1;
   localparam logic [TO_W-1:0] TMO_LOAD = TO_W'(TIMEOUT - 1);

   state_t                state_r;
   state_t                state_s;
   logic                  err_s;
   logic                  tmo_load_s;
   logic                  tmo_en_s;
   logic                  tmo_exp_s;
   logic [2*BYTE_W-1:0]   count_s;

   logic [BYTE_W-1:0]     cnt_hi_r;
   logic [BYTE_W-1:0]     hi_r;
   logic [2*BYTE_W-1:0]   remaining_r;
   logic [ADDR_W-1:0]     index_r;

   logic                  com_en_r;
   logic                  write_r;
   logic [ADDR_W-1:0]     add_r;
   logic [DATA_W-1:0]     dat_r;
   logic                  busy_r;
   logic                  done_r;
   logic                  error_r;

   assign count_s  = {cnt_hi_r, rx_data};
   assign tmo_en_s = waits_rx(state_r);

   com_timeout_ctr #(
      .W (TO_W)
   ) u_tmo (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmo_load_s),
      .en       (tmo_en_s),
      .load_val (TMO_LOAD),
      .expired  (tmo_exp_s)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode, timer reload and timeout detection.
   always_comb begin
      state_s    = state_r;
      err_s      = 1'b0;
      tmo_load_s = 1'b0;
      if (abort) begin
         state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_s    = ST_CNT_HI;
                  tmo_load_s = 1'b1;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_CNT_HI: begin
               if (rx_valid) begin
                  state_s    = ST_CNT_LO;
                  tmo_load_s = 1'b1;
               end else if (tmo_exp_s) begin
                  state_s = ST_IDLE;
                  err_s   = 1'b1;
               end else begin
                  state_s = ST_CNT_HI;
               end
            end
            ST_CNT_LO: begin
               if (rx_valid) begin
                  tmo_load_s = 1'b1;
                  if (count_s == 16'h0000) begin
                     state_s = ST_DONE;
                  end else begin
                     state_s = ST_DAT_HI;
                  end
               end else if (tmo_exp_s) begin
                  state_s = ST_IDLE;
                  err_s   = 1'b1;
               end else begin
                  state_s = ST_CNT_LO;
               end
            end
            ST_DAT_HI: begin
               if (rx_valid) begin
                  state_s    = ST_DAT_LO;
                  tmo_load_s = 1'b1;
               end else if (tmo_exp_s) begin
                  state_s = ST_IDLE;
                  err_s   = 1'b1;
               end else begin
                  state_s = ST_DAT_HI;
               end
            end
            ST_DAT_LO: begin
               if (rx_valid) begin
                  state_s    = ST_WRITE;
                  tmo_load_s = 1'b1;
               end else if (tmo_exp_s) begin
                  state_s = ST_IDLE;
                  err_s   = 1'b1;
               end else begin
                  state_s = ST_DAT_LO;
               end
            end
            ST_WRITE: begin
               // A byte landing on the strobe cycle is the next high byte.
               tmo_load_s = rx_valid;
               if (remaining_r == 16'h0001) begin
                  state_s = ST_DONE;
               end else if (rx_valid) begin
                  state_s = ST_DAT_LO;
               end else begin
                  state_s = ST_DAT_HI;
               end
            end
            ST_DONE: begin
               state_s = ST_IDLE;
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // Capture count and data bytes and track the word position in the frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_hi_r    <= 8'h00;
         hi_r        <= 8'h00;
         remaining_r <= 16'h0000;
         index_r     <= '0;
      end else begin
         case (state_r)
            ST_CNT_HI: begin
               if (rx_valid) begin
                  cnt_hi_r <= rx_data;
               end
            end
            ST_CNT_LO: begin
               if (rx_valid) begin
                  remaining_r <= count_s;
                  index_r     <= '0;
               end
            end
            ST_DAT_HI: begin
               if (rx_valid) begin
                  hi_r <= rx_data;
               end
            end
            ST_WRITE: begin
               index_r     <= index_r + ADDR_W'(1);
               remaining_r <= remaining_r - 16'h0001;
               if (rx_valid) begin
                  hi_r <= rx_data;
               end
            end
            default: begin
               hi_r <= hi_r;
            end
         endcase
      end
   end

   // Registered outputs, decoded from the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         com_en_r <= 1'b0;
         write_r  <= 1'b0;
         add_r    <= '0;
         dat_r    <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         error_r  <= 1'b0;
      end else begin
         com_en_r <= owns_port(state_s);
         write_r  <= (state_s == ST_WRITE);
         busy_r   <= (state_s != ST_IDLE);
         done_r   <= (state_s == ST_DONE);
         error_r  <= err_s;
         // Address and data are set on entry to WRITE and then held.
         if (state_s == ST_WRITE) begin
            add_r <= BASE_ADDR + index_r;
            dat_r <= {hi_r, rx_data};
         end
      end
   end

   assign com_en         = com_en_r;
   assign write_from_com = write_r;
   assign add_from_com   = add_r;
   assign dat_from_com   = dat_r;
   assign busy           = busy_r;
   assign done           = done_r;
   assign error          = error_r;

endmodule

// File: doc/com_loader.md
Name: com_loader

Overview:
- Com-side producer of the memory-select interface: turns the UART receiver's byte stream into 16-bit memory writes.
- Drives com_en, write_from_com, add_from_com and dat_from_com into the processor/Com memory-port selector.
- While com_en is high, the selector routes these signals to data memory instead of the CPU's Write/ARr/Inputs.
- Used to download a program or data image before the processor is released.

Parameters:
- ADDR_W, 16, width of add_from_com.
- DATA_W, 16, width of dat_from_com; fixed at two bytes per word.
- BASE_ADDR, 16'h0000, address of the first word written.
- TIMEOUT, 50000, clk cycles allowed between bytes before the load is abandoned.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- rx_data  in  8  received byte; valid only when rx_valid is high.
- rx_valid  in  1  one-cycle strobe per received byte.
- com_en  out  1  high for the whole load; selects the Com side in the memory mux.
- write_from_com  out  1  one-cycle memory write strobe.
- add_from_com  out  ADDR_W  write address.
- dat_from_com  out  DATA_W  write data.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when the load completes normally.
- error  out  1  one-cycle pulse on inter-byte timeout.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; internal word count, remaining count, word index and timeout counter all 0.
- Frame format: count_hi, count_lo, then count words, each sent high byte first.
- States: IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, DONE.
- IDLE:
  - start=1 -> CNT_HI next cycle; com_en=1 from that cycle on.
  - rx_valid in IDLE is ignored.
- CNT_HI / CNT_LO: each rx_valid loads one byte of the 16-bit count.
  - After CNT_LO: count==0 -> DONE; otherwise -> DAT_HI with index=0.
- DAT_HI: rx_valid latches the high byte -> DAT_LO.
- DAT_LO: rx_valid latches the low byte -> WRITE.
- WRITE (exactly one cycle):
  - write_from_com=1; add_from_com = BASE_ADDR + index, modulo 2^ADDR_W; dat_from_com = {hi,lo}.
  - Address and data are stable during the strobe cycle and hold their values afterwards.
  - index increments and remaining decrements.
  - remaining becomes 0 -> DONE; otherwise -> DAT_HI.
  - A byte arriving with rx_valid in the WRITE cycle is taken as the next high byte and the FSM goes directly to DAT_LO. It is never dropped.
- DONE (one cycle): done=1, com_en=0 in the same cycle, -> IDLE.
- Write latency: the write strobe occurs 1 cycle after the rx_valid that delivers the low byte.
- Timeout:
  - Counter clears on every rx_valid and on entry to CNT_HI.
  - It counts only in CNT_HI, CNT_LO, DAT_HI and DAT_LO.
  - Reaching TIMEOUT-1 -> error pulse for one cycle, com_en=0, -> IDLE. No done pulse; writes already issued stand.
- abort=1:
  - Next state IDLE, com_en=0, no done or error pulse.
  - In the WRITE cycle, abort does not suppress that cycle's write; abort takes priority over a simultaneous rx_valid.
- start while busy is ignored.
- rst_n asserted mid-load: immediate return to IDLE with all outputs 0. The aborted frame is not resumed.
- Count 16'hFFFF is legal. The address wraps past 2^ADDR_W-1 to 0.

Decomposition:
- Shared package com_pkg: state enum (7 states), byte-width constant, default TIMEOUT, BASE_ADDR constant.
- One natural sub-module, com_timeout_ctr: a loadable/clearable down-counter with an expiry flag, reused later by the readback transmitter.

Test Plan:
- Basic load: start, bytes 00 02 AB CD 12 34 -> writes (0000,ABCD) then (0001,1234); done 1 cycle after the second write; com_en high from start+1 until the done cycle.
- Zero count: start, bytes 00 00 -> no write_from_com; done pulse; com_en falls with done.
- Back-to-back byte in the WRITE cycle: next word's high byte 0x55 on the strobe cycle, then 0x66 -> second write data 5566; no byte lost.
- Timeout: start, byte 00, then silence for TIMEOUT cycles -> error pulse, com_en=0, busy=0, no done.
- Abort/reset mid-load: abort after 3 of 4 data bytes -> no write, IDLE next cycle. Repeat with rst_n low -> all outputs 0 asynchronously.
- Wrap: BASE_ADDR=16'hFFFF, count 2 -> writes to FFFF then 0000.
